// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//
// Purpose: owns the common data bus. Each cycle it picks one eligible
// reservation-station requester using round-robin priority. The requester
// gets a combinational grant. The winning tag and result are registered and
// broadcast to every station and to the register file on the following cycle.
//
// Ports:
//   clk         clock
//   rst         synchronous, active-high reset (wins over all other inputs)
//   flush       pipeline flush: no grant this cycle, and the pending broadcast
//               is cancelled at the next edge
//   req_valid   [NUM_REQ]         requester i presents a finished result
//   req_index   [NUM_REQ*LOCK_W]  flat, slice i = tag of requester i
//   req_result  [NUM_REQ*DATA_W]  flat, slice i = result of requester i
//   grnt        [NUM_REQ]         one-hot or zero, combinational grant
//   cdb_valid                     registered broadcast valid
//   cdb_index   [LOCK_W]          registered broadcast tag (`Reg_No_Lock when idle)
//   cdb_result  [DATA_W]          registered broadcast data (holds when idle)
//
// Optional build macro CDB_PERF_CNT_EN adds two outputs:
//   perf_bcast_cnt    [32]  posedges that carried a grant
//   perf_conflict_cnt [32]  posedges with more than one eligible requester
//                           and no flush
// Both counters saturate, reset to 0, and hold during flush.
// ---------------------------------------------------------------------------

`ifndef Reg_Lock_Width
`define Reg_Lock_Width 5
`endif
`ifndef Data_Width
`define Data_Width 32
`endif
`ifndef Reg_No_Lock
`define Reg_No_Lock {`Reg_Lock_Width{1'b1}}
`endif

module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LOCK_W  = `Reg_Lock_Width,
  parameter int DATA_W  = `Data_Width,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*LOCK_W-1:0]  req_index,
  input  logic [NUM_REQ*DATA_W-1:0]  req_result,
  output logic [NUM_REQ-1:0]         grnt,
  output logic                       cdb_valid,
  output logic [LOCK_W-1:0]          cdb_index,
  output logic [DATA_W-1:0]          cdb_result
`ifdef CDB_PERF_CNT_EN
  ,
  output logic [31:0]                perf_bcast_cnt,
  output logic [31:0]                perf_conflict_cnt
`endif
);

  localparam logic [LOCK_W-1:0] NO_LOCK = LOCK_W'(`Reg_No_Lock);

  // Unpacked views of the flat request buses.
  logic [LOCK_W-1:0] tag_v [NUM_REQ];
  logic [DATA_W-1:0] res_v [NUM_REQ];
  logic [NUM_REQ-1:0] eligible;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign tag_v[gi]    = req_index[gi*LOCK_W +: LOCK_W];
    assign res_v[gi]    = req_result[gi*DATA_W +: DATA_W];
    // A request carrying the no-lock tag has nothing to wake up, so it is
    // never granted.
    assign eligible[gi] = req_valid[gi] && (tag_v[gi] != NO_LOCK);
  end

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [LOCK_W-1:0] cdb_index_q, cdb_index_d;
  logic [DATA_W-1:0] cdb_result_q, cdb_result_d;

  logic [PTR_W-1:0]  winner;
  logic              found;
  logic              grant_any;

  // Round-robin search starting at ptr_q. The loop runs from the farthest
  // offset down to offset 0, so the last hit (the closest to ptr_q) is kept.
  always_comb begin
    int idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (eligible[PTR_W'(idx)]) begin
        winner = PTR_W'(idx);
        found  = 1'b1;
      end
    end
  end

  assign grant_any = found && !flush && !rst;

  always_comb begin
    grnt = '0;
    if (grant_any) grnt[winner] = 1'b1;
  end

  // Next-state for the pointer and the broadcast register. A flush never
  // produces a grant, so it falls into the idle branch. That branch cancels
  // any broadcast that is currently showing.
  always_comb begin
    ptr_d        = ptr_q;
    cdb_valid_d  = 1'b0;
    cdb_index_d  = NO_LOCK;
    cdb_result_d = cdb_result_q;
    if (grant_any) begin
      cdb_valid_d  = 1'b1;
      cdb_index_d  = tag_v[winner];
      cdb_result_d = res_v[winner];
      ptr_d        = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_index_q  <= NO_LOCK;
      cdb_result_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_index_q  <= cdb_index_d;
      cdb_result_q <= cdb_result_d;
    end
  end

  assign cdb_valid  = cdb_valid_q;
  assign cdb_index  = cdb_index_q;
  assign cdb_result = cdb_result_q;

`ifdef CDB_PERF_CNT_EN
  logic [31:0] bcast_cnt_q, bcast_cnt_d;
  logic [31:0] conflict_cnt_q, conflict_cnt_d;
  logic        multi_eligible;

  // More than one bit set: clearing the lowest set bit leaves something behind.
  assign multi_eligible = (eligible & (eligible - 1'b1)) != '0;

  always_comb begin
    bcast_cnt_d    = bcast_cnt_q;
    conflict_cnt_d = conflict_cnt_q;
    if (grant_any && !(&bcast_cnt_q))
      bcast_cnt_d = bcast_cnt_q + 32'd1;
    if (multi_eligible && !flush && !(&conflict_cnt_q))
      conflict_cnt_d = conflict_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcast_cnt_q    <= '0;
      conflict_cnt_q <= '0;
    end else begin
      bcast_cnt_q    <= bcast_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign perf_bcast_cnt    = bcast_cnt_q;
  assign perf_conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Self-checking bench for cdb_arbiter. A behavioural model tracks the
// round-robin pointer and the expected broadcast. The stimulus is a set of
// directed scenarios followed by randomized traffic.
// ---------------------------------------------------------------------------

`ifndef Reg_Lock_Width
`define Reg_Lock_Width 5
`endif
`ifndef Data_Width
`define Data_Width 32
`endif
`ifndef Reg_No_Lock
`define Reg_No_Lock {`Reg_Lock_Width{1'b1}}
`endif

module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int LW = `Reg_Lock_Width;
  localparam int DW = `Data_Width;
  localparam logic [LW-1:0] NO_LOCK = LW'(`Reg_No_Lock);

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [N-1:0]      req_valid;
  logic [N*LW-1:0]   req_index;
  logic [N*DW-1:0]   req_result;
  logic [N-1:0]      grnt;
  logic              cdb_valid;
  logic [LW-1:0]     cdb_index;
  logic [DW-1:0]     cdb_result;
`ifdef CDB_PERF_CNT_EN
  logic [31:0]       perf_bcast_cnt;
  logic [31:0]       perf_conflict_cnt;
`endif

  logic [LW-1:0] tags [N];
  logic [DW-1:0] ress [N];

  always #5 clk = ~clk;

  always_comb begin
    req_index  = '0;
    req_result = '0;
    for (int i = 0; i < N; i++) begin
      req_index[i*LW +: LW]  = tags[i];
      req_result[i*DW +: DW] = ress[i];
    end
  end

  cdb_arbiter #(.NUM_REQ(N), .LOCK_W(LW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_index  (req_index),
    .req_result (req_result),
    .grnt       (grnt),
    .cdb_valid  (cdb_valid),
    .cdb_index  (cdb_index),
    .cdb_result (cdb_result)
`ifdef CDB_PERF_CNT_EN
    ,
    .perf_bcast_cnt    (perf_bcast_cnt),
    .perf_conflict_cnt (perf_conflict_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int          m_ptr = 0;
  logic        m_valid = 1'b0;
  logic [LW-1:0] m_index = '0;
  logic [DW-1:0] m_result = '0;
  longint      m_bcast = 0;
  longint      m_conf = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // The winner is the first requester in the order ptr, ptr+1, ... (mod N)
  // whose request is valid and whose tag is not the no-lock tag. -1 means
  // no winner.
  function automatic int model_winner(input logic r, input logic f, input logic [N-1:0] v);
    if (r || f) return -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (v[i] && tags[i] != NO_LOCK) return i;
    end
    return -1;
  endfunction

  function automatic int model_eligible_count(input logic [N-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < N; i++)
      if (v[i] && tags[i] != NO_LOCK) c++;
    return c;
  endfunction

  // One clock cycle. Inputs are applied just after a posedge. The grant is
  // checked mid-cycle, and the broadcast is checked just after the next
  // posedge.
  task automatic cyc(input logic r, input logic f, input logic [N-1:0] v);
    int w;
    logic [N-1:0] exp_g;
    int ne;
    rst = r; flush = f; req_valid = v;
    @(negedge clk);
    w = model_winner(r, f, v);
    exp_g = '0;
    if (w >= 0) exp_g[w] = 1'b1;
    check("grnt", 64'(grnt), 64'(exp_g));
    ne = model_eligible_count(v);
    @(posedge clk);
    #1;
    if (r) begin
      m_ptr = 0; m_valid = 1'b0; m_index = NO_LOCK; m_result = '0;
      m_bcast = 0; m_conf = 0;
    end else begin
      if (w >= 0) begin
        m_valid = 1'b1; m_index = tags[w]; m_result = ress[w];
        m_ptr = (w + 1) % N;
        if (m_bcast < 64'hFFFF_FFFF) m_bcast++;
      end else begin
        m_valid = 1'b0; m_index = NO_LOCK;
      end
      if (ne > 1 && !f && m_conf < 64'hFFFF_FFFF) m_conf++;
    end
    check("cdb_valid", 64'(cdb_valid), 64'(m_valid));
    check("cdb_index", 64'(cdb_index), 64'(m_index));
    check("cdb_result", 64'(cdb_result), 64'(m_result));
`ifdef CDB_PERF_CNT_EN
    check("perf_bcast", 64'(perf_bcast_cnt), 64'(m_bcast));
    check("perf_conflict", 64'(perf_conflict_cnt), 64'(m_conf));
`endif
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = '0;
    for (int i = 0; i < N; i++) begin
      tags[i] = LW'(i + 1);
      ress[i] = DW'(32'h100 + i);
    end
    @(posedge clk); #1;

    // Reset held two cycles with every requester asserting.
    cyc(1'b1, 1'b0, 4'b1111);
    cyc(1'b1, 1'b0, 4'b1111);
    check("reset_valid", 64'(cdb_valid), 64'd0);
    check("reset_index", 64'(cdb_index), 64'(NO_LOCK));
    check("reset_result", 64'(cdb_result), 64'd0);

    // Single requester 2 from ptr=0; the next grant must start at 3.
    tags[2] = LW'(5); ress[2] = DW'(32'hAA);
    cyc(1'b0, 1'b0, 4'b0100);
    check("single_index", 64'(cdb_index), 64'd5);
    check("single_result", 64'(cdb_result), 64'hAA);
    cyc(1'b0, 1'b0, 4'b1111);

    // Round robin from ptr=0 with all requesters eligible.
    cyc(1'b1, 1'b0, 4'b0000);
    for (int c = 0; c < 8; c++) cyc(1'b0, 1'b0, 4'b1111);
`ifdef CDB_PERF_CNT_EN
    check("rr_conflicts", 64'(perf_conflict_cnt), 64'd8);
`endif

    // No-lock filtering: requester 0 carries the no-lock tag.
    cyc(1'b1, 1'b0, 4'b0000);
    tags[0] = NO_LOCK; tags[1] = LW'(7);
    cyc(1'b0, 1'b0, 4'b0011);
    check("nolock_index", 64'(cdb_index), 64'd7);
    tags[0] = LW'(1);

    // Flush right after a grant to requester 2.
    cyc(1'b1, 1'b0, 4'b0000);
    cyc(1'b0, 1'b0, 4'b0100);
    rst = 1'b0; flush = 1'b1; req_valid = 4'b1111;
    @(negedge clk);
    check("flush_shows_prev", 64'(cdb_valid), 64'd1);
    @(posedge clk); #1;
    cyc(1'b0, 1'b1, 4'b1111);
    cyc(1'b0, 1'b0, 4'b1111);   // ptr held at 3 across the flush
    check("after_flush_index", 64'(cdb_index), 64'(tags[3]));

    // Idle after traffic: the result holds.
    ress[1] = DW'(32'h1234);
    cyc(1'b0, 1'b0, 4'b0010);
    cyc(1'b0, 1'b0, 4'b0000);
    check("idle_result", 64'(cdb_result), 64'h1234);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        tags[i] = ($urandom_range(0, 5) == 0) ? NO_LOCK : LW'($urandom);
        ress[i] = DW'($urandom);
      end
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0), N'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
